chess_clock_ctrl: RTL and testbench

Two-player countdown controller that time-shares one WIDTH-bit decrement datapath between player A and player B. A prescaler turns the system clock into decrement ticks. The active player's remaining time decrements by one on each tick, and the turn passes to the opponent on a button press. The block sits above the 16-bit decrementer in the timer subsystem and owns load, start/pause, turn arbitration and timeout detection.

---
 rtl/chess_clock_ctrl.sv | 206 ++++++++++++++++++++
 tb/tb_chess_clock_ctrl.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/chess_clock_ctrl.sv
// chess_clock_ctrl
//
// Two-player countdown controller. One decrement datapath is shared between
// player A and player B. A prescaler turns clk into decrement ticks, the
// active player's counter decrements once per tick, and the turn passes to
// the opponent on that player's switch button. Owns load, start/pause, turn
// arbitration and timeout detection.
//
// Parameters
//   WIDTH     width of each player's time counter
//   PRESCALE  clk cycles per decrement tick (>= 1)
//
// Ports
//   clk        system clock, rising edge
//   rst        asynchronous reset, active low
//   load       load time_init into both counters (IDLE/PAUSED/TIMEOUT only)
//   time_init  initial time for both players
//   start      start from IDLE (A first) or resume from PAUSED
//   pause      freeze the running clock
//   switch_a   player A ends turn (RUN_A only)
//   switch_b   player B ends turn (RUN_B only)
//   time_a     remaining time of player A
//   time_b     remaining time of player B
//   turn       0 = A active/last active, 1 = B
//   state      IDLE=0, RUN_A=1, RUN_B=2, PAUSED=3, TIMEOUT=4
//   tick       one-cycle pulse aligned with a freshly decremented counter
//   flag_a     A ran out of time (sticky until load/reset)
//   flag_b     B ran out of time (sticky until load/reset)

module chess_clock_ctrl #(
    parameter int WIDTH    = 16,
    parameter int PRESCALE = 10
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [WIDTH-1:0] time_init,
    input  logic             start,
    input  logic             pause,
    input  logic             switch_a,
    input  logic             switch_b,
    output logic [WIDTH-1:0] time_a,
    output logic [WIDTH-1:0] time_b,
    output logic             turn,
    output logic [2:0]       state,
    output logic             tick,
    output logic             flag_a,
    output logic             flag_b
);

    localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [PW-1:0] PRESC_LAST = PW'(PRESCALE - 1);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        RUN_A   = 3'd1,
        RUN_B   = 3'd2,
        PAUSED  = 3'd3,
        TIMEOUT = 3'd4
    } state_e;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] time_a_q, time_a_d;
    logic [WIDTH-1:0] time_b_q, time_b_d;
    logic [PW-1:0]    presc_q, presc_d;
    logic             turn_q, turn_d;
    logic             tick_q, tick_d;
    logic             flag_a_q, flag_a_d;
    logic             flag_b_q, flag_b_d;

    logic             running;
    logic             isRunB;
    logic [WIDTH-1:0] activeTime;
    logic [WIDTH-1:0] decTime;
    logic             ownSwitch;
    logic             tickDue;
    logic             expire;
    logic             switchTaken;
    logic             loadTaken;

    // Shared run-time decisions. Pause outranks the tick, and an expiring
    // tick outranks the switch. A zero counter is never decremented further,
    // it only forces the timeout.
    always_comb begin
        running     = (state_q == RUN_A) || (state_q == RUN_B);
        isRunB      = (state_q == RUN_B);
        activeTime  = isRunB ? time_b_q : time_a_q;
        ownSwitch   = isRunB ? switch_b : switch_a;
        decTime     = (activeTime == '0) ? '0 : activeTime - WIDTH'(1);
        tickDue     = running && !pause && (presc_q == PRESC_LAST);
        expire      = tickDue && (decTime == '0);
        switchTaken = running && !pause && !expire && ownSwitch;
        loadTaken   = load && ((state_q == IDLE) || (state_q == PAUSED) ||
                               (state_q == TIMEOUT));
    end

    // State and datapath registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= IDLE;
            time_a_q <= '0;
            time_b_q <= '0;
            presc_q  <= '0;
            turn_q   <= 1'b0;
            tick_q   <= 1'b0;
            flag_a_q <= 1'b0;
            flag_b_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            time_a_q <= time_a_d;
            time_b_q <= time_b_d;
            presc_q  <= presc_d;
            turn_q   <= turn_d;
            tick_q   <= tick_d;
            flag_a_q <= flag_a_d;
            flag_b_q <= flag_b_d;
        end
    end

    // Next-state logic. Load beats start wherever both are legal.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                if (!load && start) begin
                    state_d = (time_a_q == '0) ? TIMEOUT : RUN_A;
                end
            end
            RUN_A, RUN_B: begin
                if (pause) begin
                    state_d = PAUSED;
                end else if (expire) begin
                    state_d = TIMEOUT;
                end else if (switchTaken) begin
                    state_d = isRunB ? RUN_A : RUN_B;
                end
            end
            PAUSED: begin
                if (load) begin
                    state_d = IDLE;
                end else if (start) begin
                    state_d = turn_q ? RUN_B : RUN_A;
                end
            end
            TIMEOUT: begin
                if (load) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Datapath and registered-output next values. On a tick that coincides
    // with a switch the decrement lands first, then the switch restarts the
    // prescaler for the new player.
    always_comb begin
        time_a_d = time_a_q;
        time_b_d = time_b_q;
        presc_d  = presc_q;
        turn_d   = turn_q;
        tick_d   = 1'b0;
        flag_a_d = flag_a_q;
        flag_b_d = flag_b_q;

        if (loadTaken) begin
            time_a_d = time_init;
            time_b_d = time_init;
            flag_a_d = 1'b0;
            flag_b_d = 1'b0;
        end else if ((state_q == IDLE) && start) begin
            presc_d = '0;
            turn_d  = 1'b0;
            if (time_a_q == '0) begin
                flag_a_d = 1'b1;
            end
        end else if (running && !pause) begin
            if (tickDue) begin
                tick_d  = 1'b1;
                presc_d = '0;
                if (isRunB) begin
                    time_b_d = decTime;
                    if (expire) flag_b_d = 1'b1;
                end else begin
                    time_a_d = decTime;
                    if (expire) flag_a_d = 1'b1;
                end
            end else begin
                presc_d = presc_q + PW'(1);
            end
            if (switchTaken) begin
                presc_d = '0;
                turn_d  = ~turn_q;
            end
        end
    end

    assign time_a = time_a_q;
    assign time_b = time_b_q;
    assign turn   = turn_q;
    assign state  = state_q;
    assign tick   = tick_q;
    assign flag_a = flag_a_q;
    assign flag_b = flag_b_q;

endmodule

// File: tb/tb_chess_clock_ctrl.sv
// Directed testbench for chess_clock_ctrl with PRESCALE=4, WIDTH=16.
// Inputs change 1ns after each rising edge; outputs are sampled there too.

module tb_chess_clock_ctrl;

    localparam int WIDTH    = 16;
    localparam int PRESCALE = 4;

    localparam int S_IDLE    = 0;
    localparam int S_RUN_A   = 1;
    localparam int S_RUN_B   = 2;
    localparam int S_PAUSED  = 3;
    localparam int S_TIMEOUT = 4;

    logic             clk;
    logic             rst;
    logic             load;
    logic [WIDTH-1:0] timeInit;
    logic             start;
    logic             pause;
    logic             switchA;
    logic             switchB;
    logic [WIDTH-1:0] timeA;
    logic [WIDTH-1:0] timeB;
    logic             turn;
    logic [2:0]       state;
    logic             tick;
    logic             flagA;
    logic             flagB;

    int vectors     = 0;
    int miscompares = 0;

    chess_clock_ctrl #(
        .WIDTH    (WIDTH),
        .PRESCALE (PRESCALE)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .load      (load),
        .time_init (timeInit),
        .start     (start),
        .pause     (pause),
        .switch_a  (switchA),
        .switch_b  (switchB),
        .time_a    (timeA),
        .time_b    (timeB),
        .turn      (turn),
        .state     (state),
        .tick      (tick),
        .flag_a    (flagA),
        .flag_b    (flagB)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] obs,
                               input logic [31:0] exp);
        vectors++;
        if (obs !== exp) begin
            miscompares++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Drive one cycle of inputs, wait for the edge, then release pulses.
    task automatic applyStimulus(input logic ld, input logic st, input logic pa,
                                 input logic sa, input logic sb,
                                 input logic [WIDTH-1:0] ti);
        load     = ld;
        start    = st;
        pause    = pa;
        switchA  = sa;
        switchB  = sb;
        timeInit = ti;
        @(posedge clk);
        #1;
        load    = 1'b0;
        start   = 1'b0;
        pause   = 1'b0;
        switchA = 1'b0;
        switchB = 1'b0;
    endtask

    task automatic idleCycles(input int n);
        for (int i = 0; i < n; i++) applyStimulus(0, 0, 0, 0, 0, 16'h0);
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish, expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        rst      = 1'b1;
        load     = 1'b0;
        start    = 1'b0;
        pause    = 1'b0;
        switchA  = 1'b0;
        switchB  = 1'b0;
        timeInit = '0;
        #2;
        rst      = 1'b0;
        load     = 1'($urandom);
        start    = 1'($urandom);
        pause    = 1'($urandom);
        switchA  = 1'($urandom);
        switchB  = 1'($urandom);
        timeInit = 16'($urandom);
        repeat (2) @(posedge clk);
        #1;
        checkOutput("rst_state",  32'(state), S_IDLE);
        checkOutput("rst_turn",   32'(turn),  0);
        checkOutput("rst_time_a", 32'(timeA), 0);
        checkOutput("rst_time_b", 32'(timeB), 0);
        checkOutput("rst_flag_a", 32'(flagA), 0);
        checkOutput("rst_flag_b", 32'(flagB), 0);
        checkOutput("rst_tick",   32'(tick),  0);
        load = 0; start = 0; pause = 0; switchA = 0; switchB = 0;
        rst  = 1'b1;
        idleCycles(3);
        checkOutput("post_rst_state",  32'(state), S_IDLE);
        checkOutput("post_rst_time_a", 32'(timeA), 0);

        // A runs out of time from 3.
        applyStimulus(1, 0, 0, 0, 0, 16'h0003);
        checkOutput("t1_load_a",     32'(timeA), 3);
        checkOutput("t1_load_b",     32'(timeB), 3);
        checkOutput("t1_load_state", 32'(state), S_IDLE);
        applyStimulus(0, 1, 0, 0, 0, 16'h0);
        checkOutput("t1_start_state", 32'(state), S_RUN_A);
        checkOutput("t1_start_turn",  32'(turn),  0);
        idleCycles(3);
        checkOutput("t1_k3_time_a", 32'(timeA), 3);
        checkOutput("t1_k3_tick",   32'(tick),  0);
        idleCycles(1);
        checkOutput("t1_k4_time_a", 32'(timeA), 2);
        checkOutput("t1_k4_tick",   32'(tick),  1);
        idleCycles(1);
        checkOutput("t1_k5_tick", 32'(tick), 0);
        idleCycles(3);
        checkOutput("t1_k8_time_a", 32'(timeA), 1);
        idleCycles(4);
        checkOutput("t1_k12_time_a", 32'(timeA), 0);
        checkOutput("t1_k12_state",  32'(state), S_TIMEOUT);
        checkOutput("t1_k12_flag_a", 32'(flagA), 1);
        checkOutput("t1_k12_flag_b", 32'(flagB), 0);
        checkOutput("t1_k12_time_b", 32'(timeB), 3);
        checkOutput("t1_k12_tick",   32'(tick),  1);
        applyStimulus(0, 1, 0, 0, 0, 16'h0);
        checkOutput("t1_start_ign_state",  32'(state), S_TIMEOUT);
        checkOutput("t1_start_ign_time_a", 32'(timeA), 0);
        checkOutput("t1_start_ign_tick",   32'(tick),  0);

        // Switch to B, load ignored while running, pause and resume.
        applyStimulus(1, 0, 0, 0, 0, 16'h0010);
        checkOutput("t2_load_state",  32'(state), S_IDLE);
        checkOutput("t2_load_flag_a", 32'(flagA), 0);
        applyStimulus(0, 1, 0, 0, 0, 16'h0);
        idleCycles(4);
        checkOutput("t2_k4_time_a", 32'(timeA), 16'h000F);
        idleCycles(1);
        applyStimulus(0, 0, 0, 1, 0, 16'h0);
        checkOutput("t2_sw_time_a", 32'(timeA), 16'h000F);
        checkOutput("t2_sw_turn",   32'(turn),  1);
        checkOutput("t2_sw_state",  32'(state), S_RUN_B);
        idleCycles(3);
        checkOutput("t2_s3_time_b", 32'(timeB), 16'h0010);
        idleCycles(1);
        checkOutput("t2_s4_time_b", 32'(timeB), 16'h000F);
        checkOutput("t2_s4_time_a", 32'(timeA), 16'h000F);
        checkOutput("t2_s4_tick",   32'(tick),  1);
        applyStimulus(1, 0, 0, 0, 0, 16'h0077);
        checkOutput("t2_run_load_state",  32'(state), S_RUN_B);
        checkOutput("t2_run_load_time_b", 32'(timeB), 16'h000F);
        checkOutput("t2_run_load_time_a", 32'(timeA), 16'h000F);
        idleCycles(1);
        for (int i = 0; i < 20; i++) applyStimulus(0, 0, 1, 0, 0, 16'h0);
        checkOutput("t2_pause_state",  32'(state), S_PAUSED);
        checkOutput("t2_pause_time_b", 32'(timeB), 16'h000F);
        checkOutput("t2_pause_tick",   32'(tick),  0);
        applyStimulus(0, 1, 0, 0, 0, 16'h0);
        checkOutput("t2_resume_state",  32'(state), S_RUN_B);
        checkOutput("t2_resume_time_b", 32'(timeB), 16'h000F);
        idleCycles(1);
        checkOutput("t2_p1_time_b", 32'(timeB), 16'h000F);
        idleCycles(1);
        checkOutput("t2_p2_time_b", 32'(timeB), 16'h000E);
        checkOutput("t2_p2_tick",   32'(tick),  1);

        // Tick and switch coincide on A's last unit.
        applyStimulus(0, 0, 1, 0, 0, 16'h0);
        checkOutput("t3_pause_state", 32'(state), S_PAUSED);
        applyStimulus(1, 0, 0, 0, 0, 16'h0002);
        checkOutput("t3_load_state",  32'(state), S_IDLE);
        checkOutput("t3_load_time_a", 32'(timeA), 2);
        applyStimulus(0, 1, 0, 0, 0, 16'h0);
        checkOutput("t3_start_turn", 32'(turn), 0);
        idleCycles(1);
        applyStimulus(0, 0, 0, 0, 1, 16'h0);
        checkOutput("t3_swb_state", 32'(state), S_RUN_A);
        checkOutput("t3_swb_turn",  32'(turn),  0);
        idleCycles(2);
        checkOutput("t3_k4_time_a", 32'(timeA), 1);
        idleCycles(3);
        applyStimulus(0, 0, 0, 1, 0, 16'h0);
        checkOutput("t3_to_time_a", 32'(timeA), 0);
        checkOutput("t3_to_flag_a", 32'(flagA), 1);
        checkOutput("t3_to_state",  32'(state), S_TIMEOUT);
        checkOutput("t3_to_turn",   32'(turn),  0);
        checkOutput("t3_to_tick",   32'(tick),  1);

        // Asynchronous reset while B is running.
        applyStimulus(1, 0, 0, 0, 0, 16'h0020);
        applyStimulus(0, 1, 0, 0, 0, 16'h0);
        idleCycles(1);
        applyStimulus(0, 0, 0, 1, 0, 16'h0);
        idleCycles(5);
        checkOutput("t4_pre_state",  32'(state), S_RUN_B);
        checkOutput("t4_pre_time_b", 32'(timeB), 16'h001F);
        checkOutput("t4_pre_turn",   32'(turn),  1);
        #3;
        rst = 1'b0;
        #1;
        checkOutput("t4_arst_state",  32'(state), S_IDLE);
        checkOutput("t4_arst_time_a", 32'(timeA), 0);
        checkOutput("t4_arst_time_b", 32'(timeB), 0);
        checkOutput("t4_arst_turn",   32'(turn),  0);
        checkOutput("t4_arst_flags",  32'({flagA, flagB}), 0);
        #2;
        rst = 1'b1;
        applyStimulus(1, 1, 0, 0, 0, 16'h0005);
        checkOutput("t4_ldst_state",  32'(state), S_IDLE);
        checkOutput("t4_ldst_time_a", 32'(timeA), 5);
        checkOutput("t4_ldst_time_b", 32'(timeB), 5);
        idleCycles(2);
        checkOutput("t4_hold_state",  32'(state), S_IDLE);
        checkOutput("t4_hold_time_a", 32'(timeA), 5);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
